// File: rtl/instr_sequencer.sv
// Program sequencer: fetches instruction words from a synchronous ROM and issues them to the CU.
// It handles HALT/JMP/JZ/JC itself and holds memory instructions on instr_out for the Memory block.
module instr_sequencer #(
    parameter int PC_W    = 5,
    parameter int IW      = 15,
    parameter int MEM_LAT = 1
) (
    input  logic            clk_seq,
    input  logic            rst_seq,
    input  logic            run,
    output logic [PC_W-1:0] pgm_addr,
    input  logic [IW-1:0]   pgm_data,
    output logic [IW-1:0]   instr_out,
    output logic            instr_valid,
    input  logic [1:0]      flag,
    output logic            busy,
    output logic            halted,
    output logic [PC_W-1:0] pc,
    output logic [7:0]      icount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_EXEC,
        S_HALTED
    } state_t;

    // Remaining EXEC cycles after the first one: H-1.
    localparam logic [2:0] MEM_HOLD = 3'(MEM_LAT);

    state_t          state_reg;
    logic [PC_W-1:0] pc_reg;
    logic [IW-1:0]   instr_reg;
    logic            valid_reg;
    logic [7:0]      icount_reg;
    logic [2:0]      hold_reg;

    logic [3:0]      opcode;
    logic [1:0]      sub_op;
    logic [PC_W-1:0] target;
    logic            is_ctrl;
    logic            is_mem;
    logic            taken;
    logic            unused_bits;

    assign opcode      = pgm_data[14:11];
    assign sub_op      = pgm_data[10:9];
    assign target      = pgm_data[PC_W-1:0];
    assign is_ctrl     = (opcode == 4'b1111);
    assign is_mem      = (opcode == 4'b1100) || (opcode == 4'b1101);
    assign unused_bits = ^pgm_data;

    always_comb begin
        taken = 1'b0;
        case (sub_op)
            2'b01:   taken = 1'b1;
            2'b10:   taken = flag[0];
            2'b11:   taken = flag[1];
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk_seq) begin
        if (rst_seq) begin
            state_reg  <= S_IDLE;
            pc_reg     <= '0;
            instr_reg  <= '0;
            valid_reg  <= 1'b0;
            icount_reg <= '0;
            hold_reg   <= '0;
        end else begin
            case (state_reg)
                S_IDLE, S_HALTED: begin
                    if (run) begin
                        pc_reg    <= '0;
                        state_reg <= S_FETCH;
                    end
                end
                S_FETCH: state_reg <= S_ISSUE;
                S_ISSUE: begin
                    if (is_ctrl) begin
                        if (sub_op == 2'b00) begin
                            pc_reg    <= pc_reg + 1'b1;
                            state_reg <= S_HALTED;
                        end else begin
                            pc_reg    <= taken ? target : pc_reg + 1'b1;
                            state_reg <= S_FETCH;
                        end
                    end else begin
                        instr_reg <= pgm_data;
                        valid_reg <= 1'b1;
                        pc_reg    <= pc_reg + 1'b1;
                        hold_reg  <= is_mem ? MEM_HOLD : 3'd0;
                        state_reg <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (hold_reg == 3'd0) begin
                        // Drop to NOP so the CU never re-executes a stale word.
                        instr_reg  <= '0;
                        valid_reg  <= 1'b0;
                        icount_reg <= icount_reg + 1'b1;
                        state_reg  <= S_FETCH;
                    end else begin
                        hold_reg <= hold_reg - 1'b1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // The ROM address tracks pc; it is meaningful during FETCH.
    assign pgm_addr    = pc_reg;
    assign pc          = pc_reg;
    assign instr_out   = instr_reg;
    assign instr_valid = valid_reg;
    assign icount      = icount_reg;
    assign busy        = (state_reg == S_FETCH) || (state_reg == S_ISSUE) || (state_reg == S_EXEC);
    assign halted      = (state_reg == S_HALTED);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer with a behavioural synchronous program ROM.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_seq = 1'b0;
    logic        run = 1'b0;
    logic [4:0]  pgm_addr;
    logic [14:0] pgm_data;
    logic [14:0] instr_out;
    logic        instr_valid;
    logic [1:0]  flag = 2'b00;
    logic        busy;
    logic        halted;
    logic [4:0]  pc;
    logic [7:0]  icount;

    logic [14:0] rom [32];
    int checks = 0;
    int errors = 0;
    int valid_seen;

    instr_sequencer #(.PC_W(5), .IW(15), .MEM_LAT(1)) dut (
        .clk_seq(clk), .rst_seq(rst_seq), .run(run), .pgm_addr(pgm_addr),
        .pgm_data(pgm_data), .instr_out(instr_out), .instr_valid(instr_valid),
        .flag(flag), .busy(busy), .halted(halted), .pc(pc), .icount(icount)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pgm_data <= rom[pgm_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 32; i++) rom[i] = 15'h0000;
    endtask

    task automatic do_reset();
        rst_seq = 1'b1;
        tick();
        rst_seq = 1'b0;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic wait_halted(input string tag);
        int n = 0;
        while (!halted && n < 50) begin
            tick();
            n++;
        end
        check(tag, {31'd0, halted}, 32'd1);
    endtask

    initial begin
        pgm_data = '0;
        clear_rom();

        // Reset state
        do_reset();
        check("rst_pc", {27'd0, pc}, 32'd0);
        check("rst_addr", {27'd0, pgm_addr}, 32'd0);
        check("rst_instr", {17'd0, instr_out}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_icount", {24'd0, icount}, 32'd0);
        $display("reset: pc=%0d busy=%0b halted=%0b icount=%0d", pc, busy, halted, icount);

        // LOAD_DIR then HALT
        rom[0] = 15'h7235;
        rom[1] = 15'h7800;
        pulse_run();
        check("ld_fetch_busy", {31'd0, busy}, 32'd1);
        check("ld_fetch_addr", {27'd0, pgm_addr}, 32'd0);
        tick();
        check("ld_issue_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        check("ld_exec_instr", {17'd0, instr_out}, 32'h7235);
        check("ld_exec_valid", {31'd0, instr_valid}, 32'd1);
        tick();
        check("ld_done_instr", {17'd0, instr_out}, 32'd0);
        check("ld_done_valid", {31'd0, instr_valid}, 32'd0);
        check("ld_icount", {24'd0, icount}, 32'd1);
        tick();
        check("ld_halt_not_yet", {31'd0, halted}, 32'd0);
        tick();
        check("ld_halted", {31'd0, halted}, 32'd1);
        check("ld_pc", {27'd0, pc}, 32'd2);
        check("ld_busy", {31'd0, busy}, 32'd0);
        $display("load_dir+halt: icount=%0d pc=%0d halted=%0b", icount, pc, halted);

        // LOAD_MEM holds for two cycles with MEM_LAT=1; restart from HALTED
        rom[0] = 15'h6148;
        pulse_run();
        tick();
        tick();
        check("lm_cyc1_instr", {17'd0, instr_out}, 32'h6148);
        check("lm_cyc1_valid", {31'd0, instr_valid}, 32'd1);
        tick();
        check("lm_cyc2_instr", {17'd0, instr_out}, 32'h6148);
        check("lm_cyc2_valid", {31'd0, instr_valid}, 32'd1);
        tick();
        check("lm_end_instr", {17'd0, instr_out}, 32'd0);
        check("lm_end_valid", {31'd0, instr_valid}, 32'd0);
        check("lm_icount", {24'd0, icount}, 32'd2);
        wait_halted("lm_halted");
        $display("load_mem: icount=%0d halted=%0b", icount, halted);

        // JMP 3 -> HALT, no CU activity
        do_reset();
        clear_rom();
        rom[0] = 15'h7A03;
        rom[3] = 15'h7800;
        valid_seen = 0;
        pulse_run();
        check("jmp_addr0", {27'd0, pgm_addr}, 32'd0);
        tick();
        if (instr_valid) valid_seen++;
        tick();
        if (instr_valid) valid_seen++;
        check("jmp_addr3", {27'd0, pgm_addr}, 32'd3);
        tick();
        if (instr_valid) valid_seen++;
        tick();
        check("jmp_valid_never", valid_seen, 32'd0);
        check("jmp_halted", {31'd0, halted}, 32'd1);
        check("jmp_icount", {24'd0, icount}, 32'd0);
        $display("jmp: halted=%0b icount=%0d", halted, icount);

        // JZ taken / not taken, JC taken
        rom[0] = 15'h7C05;
        rom[1] = 15'h7800;
        rom[5] = 15'h7800;
        flag = 2'b01;
        pulse_run();
        tick();
        tick();
        check("jz_taken_addr", {27'd0, pgm_addr}, 32'd5);
        wait_halted("jz_taken_halt");
        flag = 2'b00;
        pulse_run();
        tick();
        tick();
        check("jz_not_taken_addr", {27'd0, pgm_addr}, 32'd1);
        wait_halted("jz_nt_halt");
        rom[0] = 15'h7E05;
        flag = 2'b10;
        pulse_run();
        tick();
        tick();
        check("jc_taken_addr", {27'd0, pgm_addr}, 32'd5);
        wait_halted("jc_taken_halt");
        flag = 2'b00;
        $display("jz/jc: branch checks done at pc=%0d", pc);

        // NOP-filled ROM: pc wraps 31->0, one retirement every 3 cycles, icount wraps
        do_reset();
        clear_rom();
        pulse_run();
        for (int k = 0; k <= 260; k++) begin
            check("nop_addr", {27'd0, pgm_addr}, k % 32);
            check("nop_icount", {24'd0, icount}, k % 256);
            tick();
            tick();
            check("nop_valid", {31'd0, instr_valid}, 32'd1);
            check("nop_instr", {17'd0, instr_out}, 32'd0);
            tick();
        end
        $display("nop sweep: pc=%0d icount=%0d", pc, icount);

        // Run while busy ignored; reset in EXEC of LOAD_MEM wins over run
        do_reset();
        clear_rom();
        rom[0] = 15'h6148;
        pulse_run();
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        check("busy_run_instr", {17'd0, instr_out}, 32'h6148);
        check("busy_run_pc", {27'd0, pc}, 32'd1);
        rst_seq = 1'b1;
        run = 1'b1;
        tick();
        rst_seq = 1'b0;
        run = 1'b0;
        check("mid_rst_instr", {17'd0, instr_out}, 32'd0);
        check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        check("mid_rst_pc", {27'd0, pc}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        tick();
        check("rst_beats_run", {31'd0, busy}, 32'd0);
        check("rst_icount", {24'd0, icount}, 32'd0);
        $display("mid-exec reset: busy=%0b pc=%0d", busy, pc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Program sequencer that fetches 15-bit instruction words from a synchronous program ROM and presents them, one at a time, to the CU's pgm_mem input.
- Owns the program counter and inserts hold cycles so that memory instructions (LOAD_MEM, STR) see a stable instruction word long enough for the Memory block.
- Executes control-flow opcodes (HALT, JMP, JZ, JC) itself; those never reach the CU.
- Sits between program ROM and CU, clocked by the same clock as clk_cu.

Parameters:
- PC_W, 5: program counter / ROM address width.
- IW, 15: instruction width; fixed to the CU format.
- MEM_LAT, 1: extra hold cycles for LOAD_MEM/STR; legal range 0..7.

Ports:
- clk_seq  input  1  clock; same net as clk_cu.
- rst_seq  input  1  reset, synchronous, active-high.
- run  input  1  start pulse; honoured only in IDLE or HALTED.
- pgm_addr  output  PC_W  ROM address; ROM returns data one cycle later.
- pgm_data  input  IW  ROM read data.
- instr_out  output  IW  instruction word to CU pgm_mem; 0 (NOP) when idle.
- instr_valid  output  1  high while instr_out carries an issued instruction.
- flag  input  2  CU flag; flag[0]=zero, flag[1]=carry.
- busy  output  1  high in FETCH/ISSUE/EXEC.
- halted  output  1  high in HALTED.
- pc  output  PC_W  current program counter.
- icount  output  8  retired executable-instruction count.

Behaviour:
- Reset (any state, mid-instruction included) takes effect at the next edge:
  - state=IDLE, pc=0, pgm_addr=0, instr_out=0, instr_valid=0, busy=0, halted=0, icount=0, hold counter=0.
- Decode on pgm_data[14:11]:
  - 0000 NOP.
  - 0001-1010 ALU.
  - 1011 MOV.
  - 1100 LOAD_MEM.
  - 1101 STR.
  - 1110 LOAD_DIR.
  - 1111 CTRL: sub-op [10:9] 00=HALT, 01=JMP, 10=JZ (taken if flag[0]), 11=JC (taken if flag[1]); target=[PC_W-1:0].
- States:
  - IDLE: on run, go to FETCH with pc=0.
  - FETCH: pgm_addr=pc for one cycle, then go to ISSUE.
  - ISSUE: pgm_data is valid.
    - Executable opcode: at the edge, instr_out<=pgm_data, instr_valid<=1, pc<=pc+1, hold<=H-1, go to EXEC.
    - CTRL opcode: instr_out stays 0, go to FETCH with pc<=target (taken) or pc+1 (not taken), or go to HALTED for HALT (pc<=pc+1).
  - EXEC: instr_out is held. If hold==0, then at the edge instr_out<=0, instr_valid<=0, icount<=icount+1, go to FETCH; otherwise decrement hold.
  - HALTED: on run, pc=0 and go to FETCH; otherwise stay.
- H=1 for NOP, ALU, MOV, LOAD_DIR; H=1+MEM_LAT for LOAD_MEM and STR. NOP issues instr_out=0 with instr_valid=1.
- Latency: each executable instruction takes 2+H cycles; each CTRL instruction takes 2.
- Flags are sampled in the ISSUE cycle. This is at least 2 cycles after the previous instruction's last EXEC cycle, so ALU flags have settled.
- Boundaries:
  - pc wraps from 2^PC_W-1 to 0.
  - icount wraps from 255 to 0.
  - run while busy is ignored.
  - run coincident with rst_seq: reset wins.
  - JMP to its own address loops forever with no CU activity (legal).
- instr_out is 0 whenever instr_valid=0, so the CU never re-executes a stale word.

Test Plan:
- Reset then run; ROM[0]=0x7235 (LOAD_DIR R2,0x35), ROM[1]=0x7800 (HALT) -> instr_out=0x7235 for exactly 1 cycle, 2 cycles after run; halted=1 two cycles later; icount=1, pc=2.
- ROM[0]=0x6148 (LOAD_MEM R1,[9]), MEM_LAT=1 -> instr_out=0x6148 with instr_valid high for exactly 2 consecutive cycles, then 0.
- ROM[0]=0x7A03 (JMP 3), ROM[3]=0x7800 -> pgm_addr sequence 0,3; instr_valid never asserted; halted=1; icount=0.
- JZ 5 (0x7C05) with flag=2'b01 -> next pgm_addr=5; same instruction with flag=2'b00 -> next pgm_addr=pc+1.
- PC_W=5, ROM filled with NOPs, run -> pgm_addr counts 0..31 then 0; icount increments by 1 every 3 cycles.
- Assert rst_seq during EXEC of LOAD_MEM -> next cycle instr_out=0, instr_valid=0, state IDLE, pc=0; run pulse while busy has no effect.
